// File: rtl/wb_bram_arbiter.sv
`timescale 1ns/1ps
// wb_bram_arbiter
// Round-robin arbiter that lets two Wishbone masters share one Wishbone slave
// (the on-chip BlockRAM). A grant covers a whole bus cycle and is held for as
// long as the owning master keeps cyc high. An ack watchdog aborts a transfer
// whose slave never acks, so the other master cannot be locked out forever.
//
// Ports
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   m0_*_i / m0_*_o       master 0 request (cyc, stb, we, adr, dat, sel) and
//                         response (dat, ack, err)
//   m1_*_i / m1_*_o       same set for master 1
//   s_*_o / s_*_i         shared slave port (cyc, stb, we, adr, dat, sel out;
//                         dat, ack in)
//   grant_o               one-hot current owner, 00 when nobody owns the bus
module wb_bram_arbiter #(
    parameter int unsigned timeout_width  = 8,
    parameter int unsigned timeout_cycles = 200
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {StIdle, StBusy0, StBusy1, StAbort} state_e;

    localparam logic [timeout_width-1:0] CountLast = timeout_width'(timeout_cycles - 1);
    localparam logic [timeout_width-1:0] CountOne  = timeout_width'(1);

    state_e                   state_q;
    logic                     last_q;   // master served most recently
    logic                     owner_q;  // master owning BUSY/ABORT
    logic                     err0_q;
    logic                     err1_q;
    logic [timeout_width-1:0] count_q;

    logic own_cyc;
    logic own_stb;

    assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
    assign own_stb = owner_q ? m1_stb_i : m0_stb_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            count_q <= '0;
        end else begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    count_q <= '0;
                    // On a tie, the master not served last wins.
                    if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                        state_q <= StBusy0;
                        owner_q <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state_q <= StBusy1;
                        owner_q <= 1'b1;
                    end
                end
                StBusy0, StBusy1: begin
                    // Priority: cyc drop beats expiry, ack beats expiry.
                    if (!own_cyc) begin
                        state_q <= StIdle;
                        last_q  <= owner_q;
                        count_q <= '0;
                    end else if (s_ack_i || !own_stb) begin
                        count_q <= '0;
                    end else if (count_q == CountLast) begin
                        state_q <= StAbort;
                        err0_q  <= ~owner_q;
                        err1_q  <= owner_q;
                    end else begin
                        count_q <= count_q + CountOne;
                    end
                end
                StAbort: begin
                    // Counter is left frozen here so it cannot wrap.
                    if (!own_cyc) begin
                        state_q <= StIdle;
                        last_q  <= owner_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_err_o = err0_q;
    assign m1_err_o = err1_q;

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        grant_o  = 2'b00;
        case (state_q)
            StBusy0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i & m0_stb_i;
                grant_o  = 2'b01;
            end
            StBusy1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i & m1_stb_i;
                grant_o  = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_bram_arbiter.sv
`timescale 1ns/1ps
// Bench for wb_bram_arbiter: BlockRAM-style slave model with a selectable
// ack source, a reference memory feeding a read-data scoreboard, and one task
// per scenario.
module tb_wb_bram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_dat, m0_dat_o;
    logic [3:0]  m0_sel;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_dat, m1_dat_o;
    logic [3:0]  m1_sel;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_ack_i;
    logic [1:0]  grant_o;

    // Slave ack source: 0 = BlockRAM model, 1 = hung (never acks), 2 = man_ack.
    int          mode = 0;
    logic        man_ack = 1'b0;
    logic        ack_q;
    logic [31:0] rdata_q;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];

    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic [1:0]  glog [$];
    logic [1:0]  gprev = 2'b00;
    bit          log_en;
    int          stray = 0;
    int          n_checks;
    int          n_pass;

    wb_bram_arbiter #(
        .timeout_width (8),
        .timeout_cycles(8)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .m0_cyc_i(m0_cyc),
        .m0_stb_i(m0_stb),
        .m0_we_i (m0_we),
        .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat),
        .m0_sel_i(m0_sel),
        .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc),
        .m1_stb_i(m1_stb),
        .m1_we_i (m1_we),
        .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat),
        .m1_sel_i(m1_sel),
        .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .grant_o (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BlockRAM model: toggle-style ack, registered read data.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= (mode == 0) && s_cyc_o && s_stb_o && !ack_q;
            if ((mode == 0) && s_cyc_o && s_stb_o && !ack_q) begin
                if (s_we_o) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_sel_o[b]) mem[s_adr_o[7:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
                    end
                end
                rdata_q <= mem[s_adr_o[7:2]];
            end
        end
    end

    assign s_dat_i = rdata_q;
    assign s_ack_i = (mode == 2) ? man_ack : ack_q;

    // Grant-change log and detection of acks routed to a non-owner.
    always @(negedge clk) begin
        if (!log_en) gprev = grant_o;
        else if (grant_o !== gprev) begin
            glog.push_back(grant_o);
            gprev = grant_o;
        end
        if ((m0_ack_o && grant_o != 2'b01) || (m1_ack_o && grant_o != 2'b10)) stray++;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: got still running at %0t, want finished", $time);
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; m1_sel = '0;
    endtask

    task automatic do_reset();
        idle_masters();
        mode    = 0;
        man_ack = 1'b0;
        rst_n   = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One single-beat transfer; read data is checked against the scoreboard.
    // wait_cyc counts sampled cycles before the grant reached this master.
    task automatic xfer(input bit id, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, output int wait_cyc);
        logic [31:0] rd;
        logic [31:0] exp_val;
        logic [1:0]  own;
        bit          got;
        own = id ? 2'b10 : 2'b01;
        if (!id) begin
            m0_cyc = 1; m0_stb = 1; m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = 4'hF;
        end else begin
            m1_cyc = 1; m1_stb = 1; m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = 4'hF;
        end
        if (we) ref_mem[adr[7:2]] = dat;
        else if (!id) exp_q0.push_back(ref_mem[adr[7:2]]);
        else exp_q1.push_back(ref_mem[adr[7:2]]);
        wait_cyc = 0;
        got      = 0;
        rd       = '0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (id ? m1_ack_o : m0_ack_o) begin
                got = 1;
                rd  = id ? m1_dat_o : m0_dat_o;
            end else if (grant_o != own) begin
                wait_cyc++;
            end
        end
        n_checks++;
        if (!got) $display("FAIL xfer_ack m%0d adr %h: got no ack in 64 cycles, want ack", id, adr);
        else n_pass++;
        if (got && !we) begin
            exp_val = id ? exp_q1.pop_front() : exp_q0.pop_front();
            n_checks++;
            if (rd !== exp_val)
                $display("FAIL read_data m%0d adr %h: got %h want %h", id, adr, rd, exp_val);
            else n_pass++;
        end
        tick();
        if (!id) begin m0_cyc = 0; m0_stb = 0; m0_we = 0; end
        else begin m1_cyc = 0; m1_stb = 0; m1_we = 0; end
        tick();
    endtask

    task automatic test_reset();
        idle_masters();
        rst_n  = 1'b0;
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h10; m0_dat = '1; m0_sel = 4'hF;
        m1_cyc = 1;
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant_o);
        else n_pass++;
        n_checks++;
        if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000)
            $display("FAIL reset_s_ctrl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o});
        else n_pass++;
        n_checks++;
        if ({s_adr_o, s_dat_o, s_sel_o} !== 68'h0)
            $display("FAIL reset_s_data: got %h want 0", {s_adr_o, s_dat_o, s_sel_o});
        else n_pass++;
        n_checks++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000)
            $display("FAIL reset_resp: got %b want 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
        else n_pass++;
        idle_masters();
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b00) $display("FAIL idle_grant: got %b want 00", grant_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_single();
        int w;
        xfer(0, 1, 32'h10, 32'hDEAD_BEEF, w);
        n_checks++;
        if (w != 1) $display("FAIL single_wr_latency: got %0d want 1", w);
        else n_pass++;
        xfer(0, 0, 32'h10, 32'h0, w);
        n_checks++;
        if (w != 1) $display("FAIL single_rd_latency: got %0d want 1", w);
        else n_pass++;
        n_checks++;
        if (stray != 0) $display("FAIL single_stray_ack: got %0d want 0", stray);
        else n_pass++;
    endtask

    task automatic test_tie();
        int w0, w1;
        do_reset();
        fork
            xfer(0, 1, 32'h30, 32'hCAFE_0030, w0);
            xfer(1, 0, 32'h10, 32'h0, w1);
        join
        n_checks++;
        if (w0 != 1 || w1 != 5) $display("FAIL tie1_order: got w0=%0d w1=%0d want 1 5", w0, w1);
        else n_pass++;
        fork
            xfer(0, 0, 32'h30, 32'h0, w0);
            xfer(1, 1, 32'h34, 32'h0A0B_0C0D, w1);
        join
        n_checks++;
        if (w0 != 1 || w1 != 5) $display("FAIL tie2_order: got w0=%0d w1=%0d want 1 5", w0, w1);
        else n_pass++;
    endtask

    task automatic test_starvation();
        logic [1:0]  pat [4];
        logic [31:0] radr [3];
        pat  = '{2'b01, 2'b00, 2'b10, 2'b00};
        radr = '{32'h30, 32'h34, 32'h10};
        do_reset();
        glog.delete();
        log_en = 1'b1;
        fork
            begin
                int w;
                for (int i = 0; i < 3; i++) xfer(0, 1, 32'h40 + 32'(4 * i), 32'h1000_0000 + 32'(i), w);
            end
            begin
                int w;
                for (int i = 0; i < 3; i++) begin
                    xfer(1, 0, radr[i], 32'h0, w);
                    n_checks++;
                    if (w > 5) $display("FAIL starve_wait m1 #%0d: got %0d want <=5", i, w);
                    else n_pass++;
                end
            end
        join
        @(negedge clk);
        #1;
        log_en = 1'b0;
        tick();
        n_checks++;
        if (glog.size() != 12) $display("FAIL starve_len: got %0d want 12", glog.size());
        else n_pass++;
        for (int i = 0; i < glog.size() && i < 12; i++) begin
            n_checks++;
            if (glog[i] !== pat[i % 4])
                $display("FAIL starve_seq[%0d]: got %b want %b", i, glog[i], pat[i % 4]);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int         rise, errc, npulse, regrant, m0_bad;
        logic       cyc_at_err;
        logic [1:0] g_at_err;
        bit         got;
        int         w;
        do_reset();
        mode = 1;
        rise = -1; errc = -1; npulse = 0; regrant = 0; m0_bad = 0;
        cyc_at_err = 1'b1; g_at_err = 2'b11;
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h50; m1_dat = 32'h5555_AAAA; m1_sel = 4'hF;
        for (int k = 0; k < 30; k++) begin
            if (k == 3) begin
                m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h20;
                m0_dat = 32'h1234_5678; m0_sel = 4'hF;
                ref_mem[8] = 32'h1234_5678;
            end
            @(negedge clk);
            if (rise < 0 && s_stb_o) rise = k;
            if (m0_err_o) m0_bad++;
            if (m1_err_o) begin
                npulse++;
                if (errc < 0) begin
                    errc       = k;
                    cyc_at_err = s_cyc_o;
                    g_at_err   = grant_o;
                end
            end else if (errc >= 0 && grant_o != 2'b00) begin
                regrant++;
            end
            tick();
        end
        n_checks++;
        if (rise != 1) $display("FAIL to_stb_rise: got cycle %0d want 1", rise);
        else n_pass++;
        n_checks++;
        if (errc - rise != 8) $display("FAIL to_err_delay: got %0d want 8", errc - rise);
        else n_pass++;
        n_checks++;
        if (npulse != 1) $display("FAIL to_err_pulses: got %0d want 1", npulse);
        else n_pass++;
        n_checks++;
        if (cyc_at_err !== 1'b0 || g_at_err !== 2'b00)
            $display("FAIL to_abort_bus: got cyc=%b grant=%b want 0 00", cyc_at_err, g_at_err);
        else n_pass++;
        n_checks++;
        if (regrant != 0 || m0_bad != 0)
            $display("FAIL to_hold: got regrant=%0d m0_err=%0d want 0 0", regrant, m0_bad);
        else n_pass++;
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
        mode = 0;
        tick();
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b00) $display("FAIL to_idle_gap: got %b want 00", grant_o);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b01) $display("FAIL to_m0_granted: got %b want 01", grant_o);
        else n_pass++;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = m0_ack_o;
        end
        n_checks++;
        if (!got) $display("FAIL to_m0_ack: got none want ack");
        else n_pass++;
        tick();
        m0_cyc = 0; m0_stb = 0; m0_we = 0;
        tick();
        xfer(0, 0, 32'h20, 32'h0, w);
        n_checks++;
        if (stray != 0) $display("FAIL to_stray_ack: got %0d want 0", stray);
        else n_pass++;
    endtask

    task automatic test_coincidence();
        do_reset();
        mode = 2;
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h60; m0_dat = 32'h6666_6666; m0_sel = 4'hF;
        repeat (8) tick();
        man_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b0)
            $display("FAIL co_ack_fwd: got ack=%b err=%b want 1 0", m0_ack_o, m0_err_o);
        else n_pass++;
        tick();
        man_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m0_err_o !== 1'b0 || grant_o !== 2'b01)
            $display("FAIL co_ack_wins: got err=%b grant=%b want 0 01", m0_err_o, grant_o);
        else n_pass++;
        repeat (7) tick();
        @(negedge clk);
        n_checks++;
        if (m0_err_o !== 1'b0) $display("FAIL co_count_cleared: got err=%b want 0", m0_err_o);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (m0_err_o !== 1'b1 || s_cyc_o !== 1'b0)
            $display("FAIL co_reexpire: got err=%b cyc=%b want 1 0", m0_err_o, s_cyc_o);
        else n_pass++;
        tick();
        man_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m0_ack_o !== 1'b0 || m0_err_o !== 1'b0)
            $display("FAIL co_abort_ack: got ack=%b err=%b want 0 0", m0_ack_o, m0_err_o);
        else n_pass++;
        m0_cyc = 0; m0_stb = 0;
        man_ack = 1'b0;
        tick();
        tick();
        m0_cyc = 1; m0_stb = 1;
        repeat (8) tick();
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        n_checks++;
        if (m0_err_o !== 1'b0) $display("FAIL co_drop_expiry: got err=%b want 0", m0_err_o);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (m0_err_o !== 1'b0 || grant_o !== 2'b00)
            $display("FAIL co_drop_idle: got err=%b grant=%b want 0 00", m0_err_o, grant_o);
        else n_pass++;
        idle_masters();
        mode = 0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = 2;
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h70; m0_dat = 32'h7777_7777; m0_sel = 4'hF;
        repeat (2) tick();
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b01 || s_cyc_o !== 1'b1)
            $display("FAIL ar_burst: got grant=%b cyc=%b want 01 1", grant_o, s_cyc_o);
        else n_pass++;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_cyc_o, s_stb_o, grant_o} !== 4'b0000)
            $display("FAIL ar_immediate: got cyc=%b stb=%b grant=%b want 0 0 00",
                     s_cyc_o, s_stb_o, grant_o);
        else n_pass++;
        m1_cyc = 1; m1_stb = 1;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b00) $display("FAIL ar_release: got %b want 00", grant_o);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (grant_o !== 2'b01) $display("FAIL ar_tie_m0: got %b want 01", grant_o);
        else n_pass++;
        idle_masters();
        tick();
        tick();
        mode = 0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        log_en   = 1'b0;
        rst_n    = 1'b0;
        idle_masters();
        test_reset();
        test_single();
        test_tie();
        test_starvation();
        test_timeout();
        test_coincidence();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_bram_arbiter.md
Name: wb_bram_arbiter

Overview:
- Two-master, round-robin Wishbone arbiter that shares a single Wishbone slave port (the on-chip BlockRAM) between requesters, e.g. CPU data bus and a DMA/loader engine.
- Grants whole bus cycles: a grant is held while the owning master holds cyc.
- Adds a per-transfer ack watchdog so a hung slave cannot lock out the other master.

Parameters:
- timeout_width, 8, width of the watchdog counter.
- timeout_cycles, 200, cycles with s_stb_o high and no s_ack_i before abort; must be >0 and <2**timeout_width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous, active-low reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle/strobe/write
- m0_adr_i  in  32  master 0 address
- m0_dat_i  in  32  master 0 write data
- m0_sel_i  in  4  master 0 byte selects
- m0_dat_o  out  32  read data to master 0
- m0_ack_o  out  1  ack to master 0
- m0_err_o  out  1  timeout error to master 0
- m1_*  same set and widths as m0_*, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_adr_o  out  32  address to slave
- s_dat_o  out  32  write data to slave
- s_sel_o  out  4  byte selects to slave
- s_dat_i  in  32  slave read data
- s_ack_i  in  1  slave ack
- grant_o  out  2  one-hot current owner (00 = none)

Behaviour:
- States: IDLE, BUSY0, BUSY1, ABORT. The state register and the last-served flag `last` are reset asynchronously by rst_n_i low: state=IDLE, last=1 (so m0 wins the first tie), watchdog count=0.
- Outputs during reset and in IDLE: s_cyc_o=s_stb_o=s_we_o=0, s_adr_o/s_dat_o/s_sel_o=0, all m*_ack_o=m*_err_o=0, grant_o=00.
- IDLE transitions:
  - only m0_cyc_i high -> BUSY0; only m1_cyc_i high -> BUSY1.
  - both high -> BUSY0 if last=1, else BUSY1.
  - Grant is registered, so the slave sees its first cycle one clock after the request.
- BUSYn forwarding: s_cyc/stb/we/adr/dat/sel come combinationally from master n.
  - mn_ack_o = s_ack_i & mn_stb_i.
  - Both m0_dat_o and m1_dat_o = s_dat_i.
  - The non-owner sees ack=0 and err=0; its requests are held off, not dropped.
  - grant_o is one-hot n.
- BUSYn exit: when mn_cyc_i is low, go to IDLE and set last<=n. There is always at least one IDLE cycle between owners, so the BlockRAM ack toggle flop sees stb low and clears.
- Back-to-back from one master: if master n drops cyc for one cycle and re-raises it while the other master requests, the other master wins, because last=n.
- Watchdog:
  - count clears on entry to BUSYn, on any s_ack_i, and whenever s_stb_o=0.
  - Otherwise, in BUSYn, it increments by 1 per cycle.
  - When count==timeout_cycles-1 with no ack, go to ABORT.
  - Pulse mn_err_o high for exactly that one cycle (ack stays 0).
- ABORT: s_cyc_o=s_stb_o=0 and grant_o=00. Hold until the aborted master's cyc_i is low, then go to IDLE with last<=n. The count saturates and never wraps.
- s_ack_i arriving in IDLE or ABORT is ignored and not forwarded.
- Simultaneous events:
  - If the owner drops cyc in the same cycle the watchdog expires, cyc-drop wins: go to IDLE with no err.
  - If ack and expiry coincide, ack wins and count clears.
- Reset mid-transfer: s_cyc_o falls immediately (asynchronously). After rst_n_i deasserts, the first edge behaves as IDLE.
- Arbitration uses cyc only; stb may toggle within an owned cycle and is forwarded as-is.

Test Plan:
- Single master: m0 writes 0xDEADBEEF to adr 0x10 with sel=0xF, then reads it back -> grant_o=01 one cycle after cyc; m0_dat_o=0xDEADBEEF on the read ack; m1_ack_o never asserts.
- Tie after reset: m0 and m1 raise cyc on the same edge -> BUSY0 first, then IDLE for one cycle after m0 drops, then BUSY1. Repeat the tie -> BUSY0 again (alternation).
- Starvation: m0 releases and re-requests every transfer while m1 holds a request -> grants strictly alternate 01,00,10,00,01...; m1 waits at most one m0 cycle.
- Timeout: slave ack tied low, timeout_cycles=8, m1 strobes -> m1_err_o pulses exactly 8 cycles after s_stb_o first rises; s_cyc_o drops that cycle; no re-grant until m1_cyc_i falls; a waiting m0 is then granted.
- Coincidence: ack arrives on the expiry cycle -> ack forwarded, no err, count cleared. Separately, cyc drops on the expiry cycle -> IDLE, no err.
- Async reset: assert rst_n_i low mid-burst between clock edges -> s_cyc_o=0 and grant_o=00 immediately; after release, m0 wins a tie.
